// File: rtl/bank_group_burst_ctrl_pkg.sv
// Shared arbiter package: FSM state encoding, default burst length,
// debug snapshot type and a small one-hot helper.
package bank_group_burst_ctrl_pkg;

  // Default number of command transfers per grant.
  localparam int DEFAULT_MAX_BURST = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_DONE    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  // Internal state snapshot. The count field is sized for the largest
  // legal MAX_BURST (16 needs 5 bits) and zero-extended from the real counter.
  typedef struct packed {
    state_e     state;
    logic [4:0] burst_cnt;
    logic [1:0] rr_ptr;
  } dbg_t;

  // One-hot decode of a 2-bit bank index.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/bank_group_burst_ctrl_if.sv
// Bundle between the bank-group burst controller and its neighbours
// (bank schedulers, group arbiter, shared command path).
//
// Handshake: a command moves when cmd_valid && cmd_ready in the same cycle.
// cmd_valid may fall without a transfer (grant lost or queues drained);
// the controller never waits on cmd_ready to lower it. bank_pop is the
// dequeue strobe for exactly the transferred command.
interface bank_group_burst_ctrl_if;
  logic [3:0] bank_valid;
  logic [3:0] bank_pop;
  logic       start;
  logic       req;
  logic       done;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_bank;

  // Controller side.
  modport master (
    input  bank_valid, start, cmd_ready,
    output bank_pop, req, done, cmd_valid, cmd_bank
  );

  // Environment side (schedulers, arbiter, command path).
  modport slave (
    output bank_valid, start, cmd_ready,
    input  bank_pop, req, done, cmd_valid, cmd_bank
  );
endinterface

// File: rtl/bank_group_burst_ctrl_rr_picker4.sv
// 4-way rotating-priority selector: returns the first set valid bit
// found scanning upward from ptr, wrapping 3 -> 0.
module rr_picker4 (
  input  logic [3:0] valid,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       any
);

  assign any = |valid;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (valid[2'(ptr + 2'(k))]) begin
        idx = 2'(ptr + 2'(k));
      end
    end
  end

endmodule

// File: rtl/bank_group_burst_ctrl.sv
// Bank-group burst controller: requests the group arbiter while any bank
// has work, then issues up to MAX_BURST commands per grant in rotating
// bank order, acknowledges the end of the burst with a one-cycle done and
// waits for the grant to be withdrawn.
module bank_group_burst_ctrl
  import bank_group_burst_ctrl_pkg::*;
#(
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic                          clk,
  input  logic                          rst_n,
  bank_group_burst_ctrl_if.master       bus,
  output dbg_t                          dbg_o
);

  localparam int            CW   = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    rr_q, rr_d;

  logic [1:0]    pick_idx;
  logic          pick_any;
  logic          cmd_valid;
  logic          xfer;

  rr_picker4 u_picker (
    .valid (bus.bank_valid),
    .ptr   (rr_q),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Handshake outputs are pure functions of state and current inputs,
  // so an asynchronous reset clears them without waiting for a clock.
  assign cmd_valid     = (state_q == ST_ISSUE) && bus.start && pick_any;
  assign xfer          = cmd_valid && bus.cmd_ready;
  assign bus.cmd_valid = cmd_valid;
  assign bus.cmd_bank  = cmd_valid ? pick_idx : 2'd0;
  assign bus.bank_pop  = xfer ? onehot4(pick_idx) : 4'b0000;
  assign bus.req       = ((state_q == ST_IDLE) || (state_q == ST_ISSUE)) && pick_any;
  assign bus.done      = (state_q == ST_DONE);

  // Next-state, burst counter and round-robin pointer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_ISSUE;
          cnt_d   = '0;
        end
      end
      ST_ISSUE: begin
        if (!bus.start) begin
          // Grant withdrawn: abandon the burst silently, keep rotation.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (!pick_any) begin
          state_d = ST_DONE;
        end else if (xfer) begin
          cnt_d = cnt_q + CW'(1);
          rr_d  = pick_idx + 2'd1;
          if (cnt_q == LAST) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = bus.start ? ST_RELEASE : ST_IDLE;
      end
      ST_RELEASE: begin
        if (!bus.start) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rr_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
    end
  end

  assign dbg_o.state     = state_q;
  assign dbg_o.burst_cnt = 5'(cnt_q);
  assign dbg_o.rr_ptr    = rr_q;

endmodule

// File: tb/tb_bank_group_burst_ctrl.sv
// Directed bench for bank_group_burst_ctrl: full burst, drain, wrap,
// backpressure, abort, asynchronous reset, and a MAX_BURST=1 instance.
module tb_bank_group_burst_ctrl;
  import bank_group_burst_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bank_group_burst_ctrl_if bus ();
  bank_group_burst_ctrl_if bus1 ();
  dbg_t dbg, dbg1;

  bank_group_burst_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .dbg_o (dbg)
  );

  bank_group_burst_ctrl #(.MAX_BURST(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1),
    .dbg_o (dbg1)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expect a transfer from the given bank in the current cycle.
  task automatic expect_xfer(input string tag, input logic [1:0] bank);
    logic [3:0] oh;
    oh = 4'b0001 << bank;
    check({tag, ".cmd_valid"}, 32'(bus.cmd_valid), 32'd1);
    check({tag, ".cmd_bank"},  32'(bus.cmd_bank),  32'(bank));
    check({tag, ".bank_pop"},  32'(bus.bank_pop),  32'(oh));
  endtask

  logic [1:0] full_order [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
  logic [1:0] wrap_order [4] = '{2'd3, 2'd0, 2'd3, 2'd0};

  initial begin
    rst_n          = 1'b0;
    bus.bank_valid = 4'b0000;
    bus.start      = 1'b0;
    bus.cmd_ready  = 1'b0;
    bus1.bank_valid = 4'b0000;
    bus1.start      = 1'b0;
    bus1.cmd_ready  = 1'b0;

    // ---- reset state ----
    #2;
    check("rst.state",     32'(dbg.state),      32'(ST_IDLE));
    check("rst.cnt",       32'(dbg.burst_cnt),  32'd0);
    check("rst.rr",        32'(dbg.rr_ptr),     32'd0);
    check("rst.done",      32'(bus.done),       32'd0);
    check("rst.cmd_valid", 32'(bus.cmd_valid),  32'd0);
    check("rst.bank_pop",  32'(bus.bank_pop),   32'd0);
    check("rst.req_idle",  32'(bus.req),        32'd0);
    bus.bank_valid = 4'b1111;
    #1;
    check("rst.req_pend",  32'(bus.req),        32'd1);
    check("rst.cmd_bank",  32'(bus.cmd_bank),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ---- full burst ----
    bus.start     = 1'b1;
    bus.cmd_ready = 1'b1;
    #1;
    check("full.latency_cv", 32'(bus.cmd_valid), 32'd0);
    check("full.idle_state", 32'(dbg.state),     32'(ST_IDLE));
    step();
    check("full.issue", 32'(dbg.state), 32'(ST_ISSUE));
    for (int i = 0; i < 4; i++) begin
      expect_xfer($sformatf("full.x%0d", i), full_order[i]);
      check("full.req", 32'(bus.req), 32'd1);
      step();
    end
    check("full.done_state", 32'(dbg.state),     32'(ST_DONE));
    check("full.done",       32'(bus.done),      32'd1);
    check("full.done_req",   32'(bus.req),       32'd0);
    check("full.done_cv",    32'(bus.cmd_valid), 32'd0);
    check("full.done_pop",   32'(bus.bank_pop),  32'd0);
    step();
    check("full.rel_state", 32'(dbg.state), 32'(ST_RELEASE));
    check("full.rel_done",  32'(bus.done),  32'd0);
    check("full.rel_req",   32'(bus.req),   32'd0);
    step();
    check("full.rel_hold", 32'(dbg.state), 32'(ST_RELEASE));
    bus.start = 1'b0;
    step();
    check("full.idle", 32'(dbg.state),  32'(ST_IDLE));
    check("full.rr",   32'(dbg.rr_ptr), 32'd0);

    // ---- drain ----
    bus.bank_valid = 4'b0100;
    bus.start      = 1'b1;
    step();
    expect_xfer("drain.x0", 2'd2);
    step();
    bus.bank_valid = 4'b0000;
    #1;
    check("drain.cv",    32'(bus.cmd_valid), 32'd0);
    check("drain.pop",   32'(bus.bank_pop),  32'd0);
    check("drain.req",   32'(bus.req),       32'd0);
    check("drain.state", 32'(dbg.state),     32'(ST_ISSUE));
    step();
    check("drain.done",  32'(bus.done),   32'd1);
    check("drain.rr",    32'(dbg.rr_ptr), 32'd3);
    bus.start = 1'b0;
    step();
    check("drain.idle",  32'(dbg.state),  32'(ST_IDLE));

    // ---- wrap: rr_ptr=3, banks 3 and 0 pending ----
    bus.bank_valid = 4'b1001;
    bus.start      = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      expect_xfer($sformatf("wrap.x%0d", i), wrap_order[i]);
      step();
    end
    check("wrap.done", 32'(bus.done),   32'd1);
    check("wrap.rr",   32'(dbg.rr_ptr), 32'd1);
    bus.start = 1'b0;
    step();

    // ---- backpressure: from rr_ptr=1 ----
    bus.bank_valid = 4'b1111;
    bus.start      = 1'b1;
    step();
    expect_xfer("bp.x0", 2'd1);
    step();
    bus.cmd_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp.cv",    32'(bus.cmd_valid), 32'd1);
      check("bp.bank",  32'(bus.cmd_bank),  32'd2);
      check("bp.pop",   32'(bus.bank_pop),  32'd0);
      check("bp.cnt",   32'(dbg.burst_cnt), 32'd1);
      check("bp.state", 32'(dbg.state),     32'(ST_ISSUE));
      step();
    end
    bus.cmd_ready = 1'b1;
    #1;
    expect_xfer("bp.x1", 2'd2);
    step();
    expect_xfer("bp.x2", 2'd3);
    step();
    expect_xfer("bp.x3", 2'd0);
    check("bp.cnt3", 32'(dbg.burst_cnt), 32'd3);
    step();
    check("bp.done", 32'(bus.done), 32'd1);
    bus.start = 1'b0;
    step();

    // ---- abort after two transfers ----
    bus.start = 1'b1;
    step();
    expect_xfer("abort.x0", 2'd1);
    step();
    expect_xfer("abort.x1", 2'd2);
    step();
    bus.start = 1'b0;
    #1;
    check("abort.cv",  32'(bus.cmd_valid), 32'd0);
    check("abort.pop", 32'(bus.bank_pop),  32'd0);
    step();
    check("abort.state", 32'(dbg.state),     32'(ST_IDLE));
    check("abort.done",  32'(bus.done),      32'd0);
    check("abort.cnt",   32'(dbg.burst_cnt), 32'd0);
    check("abort.rr",    32'(dbg.rr_ptr),    32'd3);
    bus.start = 1'b1;
    step();
    expect_xfer("abort.regrant", 2'd3);
    step();

    // ---- async reset during ISSUE ----
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.state", 32'(dbg.state),     32'(ST_IDLE));
    check("arst.cnt",   32'(dbg.burst_cnt), 32'd0);
    check("arst.rr",    32'(dbg.rr_ptr),    32'd0);
    check("arst.cv",    32'(bus.cmd_valid), 32'd0);
    check("arst.pop",   32'(bus.bank_pop),  32'd0);
    check("arst.bank",  32'(bus.cmd_bank),  32'd0);
    check("arst.done",  32'(bus.done),      32'd0);
    check("arst.req",   32'(bus.req),       32'd1);
    for (int i = 0; i < 2; i++) begin
      step();
      check("arst.hold_done",  32'(bus.done),  32'd0);
      check("arst.hold_state", 32'(dbg.state), 32'(ST_IDLE));
    end
    bus.start     = 1'b0;
    bus.cmd_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ---- MAX_BURST=1: first transfer goes straight to DONE ----
    bus1.bank_valid = 4'b1111;
    bus1.cmd_ready  = 1'b1;
    bus1.start      = 1'b1;
    step();
    check("mb1.cv",   32'(bus1.cmd_valid), 32'd1);
    check("mb1.bank", 32'(bus1.cmd_bank),  32'd0);
    check("mb1.pop",  32'(bus1.bank_pop),  32'd1);
    step();
    check("mb1.state", 32'(dbg1.state), 32'(ST_DONE));
    check("mb1.done",  32'(bus1.done),  32'd1);
    check("mb1.rr",    32'(dbg1.rr_ptr), 32'd1);
    bus1.start = 1'b0;
    step();
    check("mb1.idle", 32'(dbg1.state), 32'(ST_IDLE));

    // ---- report ----
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
